// File: rtl/audio_pkg.sv
// Shared constants, FSM state type and gain-ramp helper for the audio gain stage.
package audio_pkg;

  localparam int unsigned DATA_W    = 24;
  localparam int unsigned GAIN_W    = 16;
  localparam int unsigned GAIN_FRAC = 14;
  localparam int unsigned PROD_W    = DATA_W + GAIN_W + 1;
  localparam int unsigned RES_W     = PROD_W - GAIN_FRAC;

  localparam logic [GAIN_W-1:0]        GAIN_UNITY = 16'h4000;
  localparam logic signed [DATA_W-1:0] SAT_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN    = {1'b1, {(DATA_W-1){1'b0}}};
  // Added before the shift so the truncation rounds half up.
  localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(1 << (GAIN_FRAC - 1));

  typedef enum logic [1:0] {IDLE, MUL, SAT} state_t;

  // One ramp step from cur toward tgt; snaps onto tgt when within one step.
  function automatic logic [GAIN_W-1:0] ramp_gain(input logic [GAIN_W-1:0] cur,
                                                  input logic [GAIN_W-1:0] tgt,
                                                  input logic [GAIN_W-1:0] step);
    logic [GAIN_W-1:0] res;
    if (cur > tgt) begin
      res = ((cur - tgt) <= step) ? tgt : cur - step;
    end else begin
      res = ((tgt - cur) <= step) ? tgt : cur + step;
    end
    return res;
  endfunction

endpackage

// File: rtl/audio_gain_stage_if.sv
// Sample stream between the codec interface (master) and the gain stage (slave).
interface audio_gain_stage_if;
  import audio_pkg::*;

  logic signed [DATA_W-1:0] line_in_l;
  logic signed [DATA_W-1:0] line_in_r;
  logic                     new_sample;
  logic signed [DATA_W-1:0] hphone_l;
  logic signed [DATA_W-1:0] hphone_r;
  logic                     hphone_l_valid;

  modport master (
    output line_in_l, line_in_r, new_sample,
    input  hphone_l, hphone_r, hphone_l_valid
  );

  modport slave (
    input  line_in_l, line_in_r, new_sample,
    output hphone_l, hphone_r, hphone_l_valid
  );

endinterface

// File: rtl/audio_gain_chan.sv
// One channel datapath: capture, multiply register, round, saturate, output register.
// Optional sticky clip flag when AUDIO_GAIN_CLIP_DETECT_EN is defined.
module audio_gain_chan
  import audio_pkg::*;
(
  input  logic                     clk_100,
  input  logic                     rst_n,
  input  logic                     cap_en,
  input  logic                     mul_en,
  input  logic                     sat_en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic [GAIN_W-1:0]        g_used,
  input  logic                     bypass_used,
`ifdef AUDIO_GAIN_CLIP_DETECT_EN
  input  logic                     clip_clr,
  output logic                     clip,
`endif
  output logic signed [DATA_W-1:0] hphone
);

  logic signed [DATA_W-1:0] smp_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] smp_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] rnd;
  logic signed [RES_W-1:0]  rnd_sh;
  logic                     ovf;
  logic signed [DATA_W-1:0] sat_res;
  logic signed [DATA_W-1:0] out_q;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign smp_ext  = PROD_W'(smp_q);
  assign gain_ext = PROD_W'({1'b0, g_used});
  assign prod_d   = smp_ext * gain_ext;

  // Round half up, then saturate when the upper result bits are not a sign extension.
  always_comb begin
    rnd     = prod_q + ROUND_HALF;
    rnd_sh  = RES_W'(rnd >>> GAIN_FRAC);
    ovf     = !((&rnd_sh[RES_W-1:DATA_W-1]) || !(|rnd_sh[RES_W-1:DATA_W-1]));
    sat_res = rnd_sh[DATA_W-1:0];
    if (ovf) begin
      sat_res = rnd_sh[RES_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // Pipeline registers: sample capture, product, final output.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      smp_q  <= '0;
      prod_q <= '0;
      out_q  <= '0;
    end else begin
      if (cap_en) smp_q  <= sample;
      if (mul_en) prod_q <= prod_d;
      if (sat_en) out_q  <= bypass_used ? smp_q : sat_res;
    end
  end

`ifdef AUDIO_GAIN_CLIP_DETECT_EN
  logic clip_q;

  // Sticky clip flag; a new saturation wins over a clear in the same cycle.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      clip_q <= 1'b0;
    end else if (sat_en && !bypass_used && ovf) begin
      clip_q <= 1'b1;
    end else if (clip_clr) begin
      clip_q <= 1'b0;
    end
  end

  assign clip = clip_q;
`endif

  assign hphone = out_q;

endmodule

// File: rtl/audio_gain_stage.sv
// Stereo ramped gain stage with mute and bypass: IDLE -> MUL -> SAT, valid at N+3.
// Optional clip detection ports are enabled by AUDIO_GAIN_CLIP_DETECT_EN.
module audio_gain_stage
  import audio_pkg::*;
#(
  parameter int unsigned RAMP_STEP = 64
) (
  input  logic              clk_100,
  input  logic              rst_n,
  audio_gain_stage_if.slave audio,
  input  logic [GAIN_W-1:0] gain_target,
  input  logic              mute,
  input  logic              bypass,
`ifdef AUDIO_GAIN_CLIP_DETECT_EN
  input  logic              clip_clr,
  output logic              clip_l,
  output logic              clip_r,
`endif
  output logic [GAIN_W-1:0] gain_cur,
  output logic              sample_drop
);

  localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

  state_t              state_q, state_d;
  logic [GAIN_W-1:0]   gain_q, gain_d;
  logic [GAIN_W-1:0]   g_used_q;
  logic [GAIN_W-1:0]   tgt;
  logic                bypass_q;
  logic                valid_q;
  logic                cap_en, mul_en, sat_en;
  logic signed [DATA_W-1:0] out_l, out_r;

  assign tgt = mute ? '0 : gain_target;

  // Next state, stage enables, ramp update and drop strobe.
  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    cap_en      = 1'b0;
    mul_en      = 1'b0;
    sat_en      = 1'b0;
    sample_drop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (audio.new_sample) begin
          cap_en  = 1'b1;
          gain_d  = ramp_gain(gain_q, tgt, STEP);
          state_d = MUL;
        end
      end
      MUL: begin
        mul_en      = 1'b1;
        sample_drop = audio.new_sample;
        state_d     = SAT;
      end
      SAT: begin
        sat_en      = 1'b1;
        sample_drop = audio.new_sample;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, ramp and per-capture control registers.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gain_q   <= '0;
      g_used_q <= '0;
      bypass_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      valid_q <= sat_en;
      if (cap_en) begin
        g_used_q <= gain_q;
        bypass_q <= bypass;
      end
    end
  end

  audio_gain_chan u_chan_l (
    .clk_100     (clk_100),
    .rst_n       (rst_n),
    .cap_en      (cap_en),
    .mul_en      (mul_en),
    .sat_en      (sat_en),
    .sample      (audio.line_in_l),
    .g_used      (g_used_q),
    .bypass_used (bypass_q),
`ifdef AUDIO_GAIN_CLIP_DETECT_EN
    .clip_clr    (clip_clr),
    .clip        (clip_l),
`endif
    .hphone      (out_l)
  );

  audio_gain_chan u_chan_r (
    .clk_100     (clk_100),
    .rst_n       (rst_n),
    .cap_en      (cap_en),
    .mul_en      (mul_en),
    .sat_en      (sat_en),
    .sample      (audio.line_in_r),
    .g_used      (g_used_q),
    .bypass_used (bypass_q),
`ifdef AUDIO_GAIN_CLIP_DETECT_EN
    .clip_clr    (clip_clr),
    .clip        (clip_r),
`endif
    .hphone      (out_r)
  );

  assign audio.hphone_l       = out_l;
  assign audio.hphone_r       = out_r;
  assign audio.hphone_l_valid = valid_q;
  assign gain_cur             = gain_q;

endmodule

// File: tb/tb_audio_gain_stage.sv
// Directed self-checking bench for audio_gain_stage (clip checks when
// AUDIO_GAIN_CLIP_DETECT_EN is defined).
module tb_audio_gain_stage;

  logic        clk_100 = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] gain_target = 16'h0000;
  logic        mute   = 1'b0;
  logic        bypass = 1'b0;
  logic [15:0] gain_cur;
  logic        sample_drop;
`ifdef AUDIO_GAIN_CLIP_DETECT_EN
  logic        clip_clr = 1'b0;
  logic        clip_l;
  logic        clip_r;
`endif

  int total = 0;
  int bad   = 0;

  audio_gain_stage_if audio ();

  audio_gain_stage dut (
    .clk_100     (clk_100),
    .rst_n       (rst_n),
    .audio       (audio),
    .gain_target (gain_target),
    .mute        (mute),
    .bypass      (bypass),
`ifdef AUDIO_GAIN_CLIP_DETECT_EN
    .clip_clr    (clip_clr),
    .clip_l      (clip_l),
    .clip_r      (clip_r),
`endif
    .gain_cur    (gain_cur),
    .sample_drop (sample_drop)
  );

  always #5 clk_100 = ~clk_100;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk_100);
    #1;
  endtask

  // Issue one sample and wait (bounded) for the valid strobe.
  task automatic send(input logic [23:0] l, input logic [23:0] r,
                      output logic [23:0] out_l, output logic [23:0] out_r,
                      output int lat, output logic extra);
    audio.line_in_l  = l;
    audio.line_in_r  = r;
    audio.new_sample = 1'b1;
    step();
    lat = 1;
    audio.new_sample = 1'b0;
    while (!audio.hphone_l_valid && lat < 8) begin
      step();
      lat++;
    end
    out_l = audio.hphone_l;
    out_r = audio.hphone_r;
    step();
    extra = audio.hphone_l_valid;
  endtask

  task automatic ramp(input int n, output int misses);
    logic [23:0] ol, orr;
    int          lat;
    logic        ex;
    misses = 0;
    for (int i = 0; i < n; i++) begin
      send(24'h000100, 24'h000100, ol, orr, lat, ex);
      if (lat != 3) misses++;
    end
  endtask

  task automatic test_reset;
    audio.line_in_l  = '0;
    audio.line_in_r  = '0;
    audio.new_sample = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    total++; if (audio.hphone_l !== 24'h0) begin bad++; $display("FAIL reset_hl: got %h want 0", audio.hphone_l); end
    total++; if (audio.hphone_r !== 24'h0) begin bad++; $display("FAIL reset_hr: got %h want 0", audio.hphone_r); end
    total++; if (audio.hphone_l_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", audio.hphone_l_valid); end
    total++; if (gain_cur !== 16'h0) begin bad++; $display("FAIL reset_gain: got %h want 0", gain_cur); end
    total++; if (sample_drop !== 1'b0) begin bad++; $display("FAIL reset_drop: got %b want 0", sample_drop); end
`ifdef AUDIO_GAIN_CLIP_DETECT_EN
    total++; if ({clip_l, clip_r} !== 2'b00) begin bad++; $display("FAIL reset_clip: got %b want 00", {clip_l, clip_r}); end
`endif
  endtask

  task automatic test_fade_in;
    logic [23:0] ol, orr;
    int          lat;
    logic        ex;
    gain_target = 16'h4000;
    send(24'h123456, 24'h654321, ol, orr, lat, ex);
    total++; if (ol !== 24'h0) begin bad++; $display("FAIL fade_l: got %h want 0", ol); end
    total++; if (orr !== 24'h0) begin bad++; $display("FAIL fade_r: got %h want 0", orr); end
    total++; if (lat !== 3) begin bad++; $display("FAIL fade_latency: got %0d want 3", lat); end
    total++; if (ex !== 1'b0) begin bad++; $display("FAIL fade_valid_width: got %b want 0", ex); end
    total++; if (gain_cur !== 16'h0040) begin bad++; $display("FAIL fade_gain: got %h want 0040", gain_cur); end
  endtask

  task automatic test_unity;
    logic [23:0] ol, orr;
    int          lat, misses;
    logic        ex;
    ramp(255, misses);
    total++; if (misses !== 0) begin bad++; $display("FAIL unity_ramp_valid: got %0d want 0", misses); end
    total++; if (gain_cur !== 16'h4000) begin bad++; $display("FAIL unity_gain: got %h want 4000", gain_cur); end
    send(24'h123456, 24'hFEDCBA, ol, orr, lat, ex);
    total++; if (ol !== 24'h123456) begin bad++; $display("FAIL unity_l: got %h want 123456", ol); end
    total++; if (orr !== 24'hFEDCBA) begin bad++; $display("FAIL unity_r: got %h want fedcba", orr); end
  endtask

  task automatic test_saturate;
    logic [23:0] ol, orr;
    int          lat, misses;
    logic        ex;
    gain_target = 16'h8000;
    ramp(256, misses);
    total++; if (gain_cur !== 16'h8000) begin bad++; $display("FAIL sat_gain: got %h want 8000", gain_cur); end
    send(24'h600000, 24'hA00000, ol, orr, lat, ex);
    total++; if (ol !== 24'h7FFFFF) begin bad++; $display("FAIL sat_l: got %h want 7fffff", ol); end
    total++; if (orr !== 24'h800000) begin bad++; $display("FAIL sat_r: got %h want 800000", orr); end
`ifdef AUDIO_GAIN_CLIP_DETECT_EN
    total++; if ({clip_l, clip_r} !== 2'b11) begin bad++; $display("FAIL clip_set: got %b want 11", {clip_l, clip_r}); end
    clip_clr = 1'b1;
    step();
    clip_clr = 1'b0;
    total++; if ({clip_l, clip_r} !== 2'b00) begin bad++; $display("FAIL clip_clr: got %b want 00", {clip_l, clip_r}); end
`endif
  endtask

  task automatic test_round;
    logic [23:0] ol, orr;
    int          lat, misses;
    logic        ex;
    gain_target = 16'h2000;
    ramp(384, misses);
    total++; if (gain_cur !== 16'h2000) begin bad++; $display("FAIL round_gain: got %h want 2000", gain_cur); end
    send(24'h000001, 24'hFFFFFF, ol, orr, lat, ex);
    total++; if (ol !== 24'h000001) begin bad++; $display("FAIL round_pos1: got %h want 000001", ol); end
    total++; if (orr !== 24'h000000) begin bad++; $display("FAIL round_neg1: got %h want 000000", orr); end
    send(24'h000003, 24'h000000, ol, orr, lat, ex);
    total++; if (ol !== 24'h000002) begin bad++; $display("FAIL round_3: got %h want 000002", ol); end
  endtask

  task automatic test_mute;
    logic [23:0] ol, orr;
    int          lat, misses;
    logic        ex;
    gain_target = 16'h4000;
    ramp(128, misses);
    total++; if (gain_cur !== 16'h4000) begin bad++; $display("FAIL mute_start_gain: got %h want 4000", gain_cur); end
    mute = 1'b1;
    send(24'h000100, 24'h000100, ol, orr, lat, ex);
    total++; if (gain_cur !== 16'h3FC0) begin bad++; $display("FAIL mute_first_step: got %h want 3fc0", gain_cur); end
    ramp(255, misses);
    total++; if (gain_cur !== 16'h0000) begin bad++; $display("FAIL mute_end_gain: got %h want 0000", gain_cur); end
    bypass = 1'b1;
    send(24'h123456, 24'h800000, ol, orr, lat, ex);
    total++; if (ol !== 24'h123456) begin bad++; $display("FAIL bypass_l: got %h want 123456", ol); end
    total++; if (orr !== 24'h800000) begin bad++; $display("FAIL bypass_r: got %h want 800000", orr); end
    total++; if (lat !== 3) begin bad++; $display("FAIL bypass_latency: got %0d want 3", lat); end
    mute = 1'b0;
  endtask

  task automatic test_drop;
    int valids;
    gain_target = 16'h4000;
    bypass = 1'b1;
    audio.line_in_l  = 24'h111111;
    audio.line_in_r  = 24'h222222;
    audio.new_sample = 1'b1;
    #1;
    total++; if (sample_drop !== 1'b0) begin bad++; $display("FAIL drop_idle: got %b want 0", sample_drop); end
    step();
    audio.new_sample = 1'b0;
    step();
    audio.line_in_l  = 24'h333333;
    audio.line_in_r  = 24'h444444;
    audio.new_sample = 1'b1;
    #1;
    total++; if (sample_drop !== 1'b1) begin bad++; $display("FAIL drop_sat: got %b want 1", sample_drop); end
    step();
    audio.new_sample = 1'b0;
    total++; if (audio.hphone_l_valid !== 1'b1) begin bad++; $display("FAIL drop_valid_n3: got %b want 1", audio.hphone_l_valid); end
    total++; if (audio.hphone_l !== 24'h111111) begin bad++; $display("FAIL drop_out_l: got %h want 111111", audio.hphone_l); end
    valids = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (audio.hphone_l_valid) valids++;
    end
    total++; if (valids !== 0) begin bad++; $display("FAIL drop_extra_valid: got %0d want 0", valids); end
    total++; if (gain_cur !== 16'h0040) begin bad++; $display("FAIL drop_ramp: got %h want 0040", gain_cur); end
  endtask

  task automatic test_reset_mid;
    int valids;
    audio.line_in_l  = 24'h0ABCDE;
    audio.line_in_r  = 24'h0ABCDE;
    audio.new_sample = 1'b1;
    step();
    audio.new_sample = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    total++; if (audio.hphone_l !== 24'h0) begin bad++; $display("FAIL rstmid_hl: got %h want 0", audio.hphone_l); end
    total++; if (gain_cur !== 16'h0) begin bad++; $display("FAIL rstmid_gain: got %h want 0", gain_cur); end
    valids = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (audio.hphone_l_valid) valids++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (audio.hphone_l_valid) valids++;
    end
    total++; if (valids !== 0) begin bad++; $display("FAIL rstmid_valid: got %0d want 0", valids); end
    total++; if (audio.hphone_r !== 24'h0) begin bad++; $display("FAIL rstmid_hr: got %h want 0", audio.hphone_r); end
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_unity();
    test_saturate();
    test_round();
    test_mute();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_gain_stage.md
Name: audio_gain_stage

Overview:
Per-channel digital gain stage in the clk_100 domain between the codec interface's line-in outputs and its headphone inputs. Consumes line_in_l/line_in_r on each new_sample pulse. Applies a ramped (zipper-free) gain with mute and bypass, then rounds and saturates. Drives hphone_l/hphone_r with a one-cycle hphone_l_valid strobe, which the codec interface uses to freeze the samples.

Parameters:
DATA_W, 24, sample width, signed two's complement
GAIN_W, 16, gain width, unsigned Q2.14 (0x4000 = unity, max 0xFFFF ≈ 3.9999)
RAMP_STEP, 64, gain_cur change per accepted sample

Ports:
clk_100  in  1  system clock, 100 MHz
rst_n  in  1  reset, asynchronous, active-low
line_in_l  in  DATA_W  left input sample
line_in_r  in  DATA_W  right input sample
new_sample  in  1  one-cycle strobe: inputs valid this cycle
gain_target  in  GAIN_W  requested gain, quasi-static
mute  in  1  ramp gain toward 0
bypass  in  1  output = input; latency unchanged
hphone_l  out  DATA_W  left output sample
hphone_r  out  DATA_W  right output sample
hphone_l_valid  out  1  one-cycle strobe: outputs valid
gain_cur  out  GAIN_W  gain currently applied
sample_drop  out  1  one-cycle pulse: new_sample ignored while busy

Behaviour:
- Reset (async assert, sync release): all outputs 0; gain_cur = 0, so output fades in from silence; pipeline state IDLE.
- FSM states: IDLE -> MUL -> SAT -> IDLE.
  - IDLE: on new_sample, capture both samples, capture gain_cur as g_used, update gain_cur; go to MUL.
  - MUL: register 41-bit signed products: sample × {1'b0, g_used}.
  - SAT: round, saturate, register hphone_l/hphone_r, assert hphone_l_valid; return to IDLE.
- Latency: new_sample at cycle N -> hphone_l_valid high at N+3 for exactly one cycle. hphone_l/r hold their value until the next valid.
- new_sample during MUL or SAT: sample discarded; sample_drop pulses the same cycle; ramp not advanced.
- new_sample in the same cycle as the return to IDLE is not possible. The SAT cycle is busy, so new_sample there drops.
- Gain ramp: tgt = mute ? 0 : gain_target, evaluated at capture.
  - If |tgt − gain_cur| ≤ RAMP_STEP: gain_cur = tgt.
  - Otherwise gain_cur moves RAMP_STEP toward tgt.
  - The sample uses the pre-update value (g_used).
- Arithmetic: p = sample × g_used (41 b signed); r = (p + 2^13) >>> 14 (round half up, arithmetic shift); saturate r to [−2^23, 2^23−1].
- Bypass: hphone = captured sample, unchanged; same N+3 timing. Ramp still advances.
- Bypass/mute changes take effect at the next capture only.
- Reset mid-operation: the pipeline aborts, no valid is emitted, and all outputs return to 0.

Optional Feature:
Macro AUDIO_GAIN_CLIP_DETECT_EN.
- Defined: adds input clip_clr (1 b) and outputs clip_l and clip_r (1 b each).
  - clip_x sets in the SAT cycle when that channel saturates.
  - It is sticky until clip_clr = 1 (set wins on a simultaneous event). Reset value 0.
- Undefined: these ports and their logic are absent; saturation behaviour is unchanged.

Decomposition:
- Package audio_pkg: DATA_W, GAIN_W, GAIN_UNITY (16'h4000), GAIN_FRAC (14), SAT_MAX/SAT_MIN constants, FSM state enum (IDLE, MUL, SAT).
- Sub-module audio_gain_chan, instantiated for L and R:
  - Covers one channel's multiply register, round, saturate and clip indication.
  - Controlled by stage enables from the parent FSM.
- The parent owns the FSM, the gain ramp and the valid/drop strobes.

Test Plan:
- Reset -> all outputs 0, gain_cur 0. A new_sample 0x123456 at gain_cur 0 -> hphone_l = 0 at N+3, valid one cycle.
- gain_target 0x4000, 256 new_samples spaced 2083 cycles apart -> gain_cur = 0x4000. Next sample L = 0x123456, R = 0xFEDCBA -> outputs identical at N+3.
- Gain 0x8000 (ramped), L = 0x600000, R = 0xA00000 -> L = 0x7FFFFF, R = 0x800000. With the macro defined, clip_l and clip_r are set and cleared by clip_clr.
- Gain 0x2000: sample 1 -> 1 (round half up); sample −1 -> 0; sample 3 -> 2.
- Settled at 0x4000, raise mute -> gain_cur drops by 64 per sample and reaches 0 after 256 samples. Bypass = 1 -> output equals input regardless of gain.
- new_sample at N and N+2 -> sample_drop at N+2 and only one valid, at N+3. Assert rst_n low at N+2 -> no valid, outputs 0.
